// File: rtl/i2c_pkg.sv
// Shared state encoding and constants for the I2C slave.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddress,
        StAddrAck,
        StWriteData,
        StWriteAck,
        StReadData,
        StReadAck
    } i2c_state_e;

    // Byte returned to the master when the TX FIFO has nothing to give.
    localparam logic [7:0] IDLE_BYTE = 8'hFF;
    localparam logic [2:0] BIT_MSB   = 3'd7;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Two-flop synchronisers for SCL/SDA plus SCL edge and START/STOP detection,
// all derived from the synchronised copies.
module i2c_bus_monitor (
    input  logic clk,
    input  logic i2c_reset,
    input  logic scl_raw,
    input  logic sda_raw,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;
    logic       scl_s;

    always_ff @(posedge clk or posedge i2c_reset) begin
        if (i2c_reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_raw};
            sda_sync_q <= {sda_sync_q[0], sda_raw};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda       = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    // SDA may only change while SCL is high for bus conditions.
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda;

endmodule

// File: rtl/i2c_slave.sv
// I2C slave with 7-bit address, RX/TX FIFO strobes and open-drain bus drive.
// Define I2C_SLAVE_STRETCH_EN to stretch SCL while the TX FIFO is empty.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       i2c_reset,
    inout  wire        i2c_scl,
    inout  wire        i2c_sda,
    input  logic       i2c_slave_enable,
    input  logic [7:0] i2c_data_in,
    input  logic       fifo_tx_empty,
    output logic       fifo_tx_rd_en,
    output logic [7:0] i2c_data_out,
    output logic       fifo_rx_wr_en,
    input  logic       fifo_rx_full,
    output logic       i2c_busy
);

`ifdef I2C_SLAVE_STRETCH_EN
    localparam bit STRETCH_EN = 1'b1;
`else
    localparam bit STRETCH_EN = 1'b0;
`endif

    i2c_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_out_q, data_out_d;
    logic       sda_drive_q, sda_drive_d;
    logic       scl_drive_q, scl_drive_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;
    logic       byte_done_q, byte_done_d;
    logic       rx_ok_q, rx_ok_d;
    logic       ack_q, ack_d;
    logic       load_q, load_d;
    logic       tx_ff_q, tx_ff_d;
    logic       stretch_q, stretch_d;
    logic       rx_wr_q, rx_wr_d;
    logic       tx_rd_q, tx_rd_d;
    logic       pop_pt;

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_monitor u_bus_monitor (
        .clk       (clk),
        .i2c_reset (i2c_reset),
        .scl_raw   (i2c_scl),
        .sda_raw   (i2c_sda),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_out_d  = data_out_q;
        sda_drive_d = sda_drive_q;
        scl_drive_d = scl_drive_q;
        busy_d      = busy_q;
        rw_d        = rw_q;
        byte_done_d = byte_done_q;
        rx_ok_d     = rx_ok_q;
        ack_d       = ack_q;
        load_d      = load_q;
        tx_ff_d     = tx_ff_q;
        stretch_d   = stretch_q;
        rx_wr_d     = 1'b0;
        tx_rd_d     = 1'b0;
        pop_pt      = 1'b0;

        if (start_det || stop_det) begin
            state_d     = start_det ? StAddress : StIdle;
            bit_cnt_d   = BIT_MSB;
            sda_drive_d = 1'b0;
            scl_drive_d = 1'b0;
            busy_d      = 1'b0;
            byte_done_d = 1'b0;
            load_d      = 1'b0;
            stretch_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StAddress: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda};
                        if (bit_cnt_q == 3'd0) begin
                            if (shift_d[7:1] == SLAVE_ADDR && i2c_slave_enable) begin
                                rw_d        = sda;
                                byte_done_d = 1'b1;
                            end else begin
                                state_d = StIdle;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        state_d     = StAddrAck;
                        byte_done_d = 1'b0;
                        sda_drive_d = 1'b1;
                        busy_d      = 1'b1;
                    end
                end
                StAddrAck: begin
                    if (stretch_q) begin
                        pop_pt = !fifo_tx_empty;
                    end else if (scl_fall) begin
                        sda_drive_d = 1'b0;
                        if (rw_q) begin
                            pop_pt = 1'b1;
                        end else begin
                            state_d   = StWriteData;
                            bit_cnt_d = BIT_MSB;
                        end
                    end
                end
                StWriteData: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda};
                        if (bit_cnt_q == 3'd0) begin
                            data_out_d  = shift_d;
                            rx_wr_d     = !fifo_rx_full;
                            rx_ok_d     = !fifo_rx_full;
                            byte_done_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        state_d     = StWriteAck;
                        byte_done_d = 1'b0;
                        sda_drive_d = rx_ok_q;
                    end
                end
                StWriteAck: begin
                    if (scl_fall) begin
                        sda_drive_d = 1'b0;
                        state_d     = StWriteData;
                        bit_cnt_d   = BIT_MSB;
                    end
                end
                StReadData: begin
                    if (load_q) begin
                        // FIFO data is valid the cycle after the pop strobe.
                        if (!tx_rd_q) begin
                            shift_d     = tx_ff_q ? IDLE_BYTE : i2c_data_in;
                            sda_drive_d = !shift_d[7];
                            bit_cnt_d   = BIT_MSB;
                            load_d      = 1'b0;
                            scl_drive_d = 1'b0;
                        end
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            state_d     = StReadAck;
                            sda_drive_d = 1'b0;
                        end else begin
                            bit_cnt_d   = bit_cnt_q - 3'd1;
                            shift_d     = {shift_q[6:0], 1'b0};
                            sda_drive_d = !shift_d[7];
                        end
                    end
                end
                StReadAck: begin
                    if (stretch_q) begin
                        pop_pt = !fifo_tx_empty;
                    end else if (scl_rise) begin
                        ack_d = !sda;
                    end else if (scl_fall) begin
                        if (ack_q) begin
                            pop_pt = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase

            if (pop_pt) begin
                if (!fifo_tx_empty) begin
                    tx_rd_d   = 1'b1;
                    tx_ff_d   = 1'b0;
                    load_d    = 1'b1;
                    stretch_d = 1'b0;
                    state_d   = StReadData;
                end else if (STRETCH_EN) begin
                    stretch_d   = 1'b1;
                    scl_drive_d = 1'b1;
                end else begin
                    tx_ff_d = 1'b1;
                    load_d  = 1'b1;
                    state_d = StReadData;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge i2c_reset) begin
        if (i2c_reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= BIT_MSB;
            shift_q     <= 8'h00;
            data_out_q  <= 8'h00;
            sda_drive_q <= 1'b0;
            scl_drive_q <= 1'b0;
            busy_q      <= 1'b0;
            rw_q        <= 1'b0;
            byte_done_q <= 1'b0;
            rx_ok_q     <= 1'b0;
            ack_q       <= 1'b0;
            load_q      <= 1'b0;
            tx_ff_q     <= 1'b0;
            stretch_q   <= 1'b0;
            rx_wr_q     <= 1'b0;
            tx_rd_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_out_q  <= data_out_d;
            sda_drive_q <= sda_drive_d;
            scl_drive_q <= scl_drive_d;
            busy_q      <= busy_d;
            rw_q        <= rw_d;
            byte_done_q <= byte_done_d;
            rx_ok_q     <= rx_ok_d;
            ack_q       <= ack_d;
            load_q      <= load_d;
            tx_ff_q     <= tx_ff_d;
            stretch_q   <= stretch_d;
            rx_wr_q     <= rx_wr_d;
            tx_rd_q     <= tx_rd_d;
        end
    end

    assign i2c_sda       = sda_drive_q ? 1'b0 : 1'bz;
    assign i2c_scl       = (STRETCH_EN && scl_drive_q) ? 1'b0 : 1'bz;
    assign i2c_data_out  = data_out_q;
    assign fifo_rx_wr_en = rx_wr_q;
    assign fifo_tx_rd_en = tx_rd_q;
    assign i2c_busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: bit-banged master, FIFO models, scoreboards.
module tb_i2c_slave;

    localparam int Q = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       i2c_reset;
    logic       m_scl_low;
    logic       m_sda_low;
    logic       i2c_slave_enable;
    logic [7:0] i2c_data_in = 8'h00;
    logic       fifo_tx_empty = 1'b1;
    logic       fifo_tx_rd_en;
    logic [7:0] i2c_data_out;
    logic       fifo_rx_wr_en;
    logic       fifo_rx_full;
    logic       i2c_busy;
    wire        scl_bus;
    wire        sda_bus;

    pullup pu_scl (scl_bus);
    pullup pu_sda (sda_bus);
    assign scl_bus = m_scl_low ? 1'b0 : 1'bz;
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk              (clk),
        .i2c_reset        (i2c_reset),
        .i2c_scl          (scl_bus),
        .i2c_sda          (sda_bus),
        .i2c_slave_enable (i2c_slave_enable),
        .i2c_data_in      (i2c_data_in),
        .fifo_tx_empty    (fifo_tx_empty),
        .fifo_tx_rd_en    (fifo_tx_rd_en),
        .i2c_data_out     (i2c_data_out),
        .fifo_rx_wr_en    (fifo_rx_wr_en),
        .fifo_rx_full     (fifo_rx_full),
        .i2c_busy         (i2c_busy)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_got[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int rx_pulses = 0;
    int tx_pulses = 0;
    int bad_pops  = 0;
    int sda_slave = 0;
    int scl_slave = 0;

    // TX FIFO model: data valid the cycle after the pop strobe.
    always @(posedge clk) begin
        if (fifo_tx_rd_en && tx_q.size() > 0) i2c_data_in <= tx_q.pop_front();
    end

    always @(negedge clk) begin
        fifo_tx_empty <= (tx_q.size() == 0);
        if (fifo_tx_rd_en) tx_pulses <= tx_pulses + 1;
        if (fifo_tx_rd_en && fifo_tx_empty) bad_pops <= bad_pops + 1;
        if (fifo_rx_wr_en) begin
            rx_pulses <= rx_pulses + 1;
            rx_got.push_back(i2c_data_out);
        end
        if (!m_sda_low && sda_bus === 1'b0) sda_slave <= sda_slave + 1;
        if (!m_scl_low && scl_bus === 1'b0) scl_slave <= scl_slave + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scl_high();
        int n = 0;
        m_scl_low = 1'b0;
        while (scl_bus !== 1'b1 && n < 5000) begin
            tick(1);
            n++;
        end
        if (scl_bus !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL scl_release: scl=%b, required 1 within 5000 clks", scl_bus);
        end
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        scl_high();
        tick(Q);
        m_sda_low = 1'b1;
        tick(Q);
        m_scl_low = 1'b1;
        tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        tick(Q);
        scl_high();
        tick(Q);
        m_sda_low = 1'b0;
        tick(2 * Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = !b;
        tick(Q);
        scl_high();
        tick(2 * Q);
        m_scl_low = 1'b1;
        tick(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0;
        tick(Q);
        scl_high();
        tick(Q);
        b = sda_bus;
        tick(Q);
        m_scl_low = 1'b1;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = !b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(!ack);
    endtask

    task automatic test_reset();
        i2c_reset = 1'b1;
        tick(5);
        compared++;
        if (i2c_data_out !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_data_out: got %h, required 00", i2c_data_out);
        end
        compared++;
        if (i2c_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_busy: got %b, required 0", i2c_busy);
        end
        compared++;
        if (fifo_tx_rd_en !== 1'b0 || fifo_rx_wr_en !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_strobes: rd=%b wr=%b, required 0 0", fifo_tx_rd_en, fifo_rx_wr_en);
        end
        compared++;
        if (sda_bus !== 1'b1 || scl_bus !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_bus: sda=%b scl=%b, required 1 1", sda_bus, scl_bus);
        end
        i2c_reset = 1'b0;
        tick(5);
    endtask

    task automatic test_write();
        logic ack;
        logic [7:0] data[3] = '{8'hA0, 8'h3C, 8'h5A};
        int rx0 = rx_pulses;
        i2c_start();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) exp_q.push_back(data[i]);
            write_byte(data[i], ack);
            compared++;
            if (ack !== 1'b1) begin
                mismatched++;
                $display("FAIL write_ack[%0d]: got ack=%b, required 1", i, ack);
            end
        end
        compared++;
        if (i2c_busy !== 1'b1) begin
            mismatched++;
            $display("FAIL write_busy: got %b, required 1", i2c_busy);
        end
        i2c_stop();
        compared++;
        if (i2c_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL write_busy_stop: got %b, required 0", i2c_busy);
        end
        compared++;
        if (rx_pulses - rx0 != 2) begin
            mismatched++;
            $display("FAIL write_pulses: got %0d, required 2", rx_pulses - rx0);
        end
        compared++;
        if (i2c_data_out !== 8'h5A) begin
            mismatched++;
            $display("FAIL write_data_out: got %h, required 5a", i2c_data_out);
        end
        while (exp_q.size() > 0) begin
            logic [7:0] e = exp_q.pop_front();
            logic [7:0] g = rx_got.size() > 0 ? rx_got.pop_front() : 8'hxx;
            compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL write_rx_byte: got %h, required %h", g, e);
            end
        end
    endtask

    task automatic test_addr_nack();
        logic ack;
        int rx0 = rx_pulses;
        int tx0 = tx_pulses;
        int s0  = sda_slave;
        i2c_start();
        write_byte(8'hA2, ack);
        compared++;
        if (ack !== 1'b0) begin
            mismatched++;
            $display("FAIL nack_addr_ack: got ack=%b, required 0", ack);
        end
        compared++;
        if (i2c_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL nack_busy: got %b, required 0", i2c_busy);
        end
        i2c_stop();
        compared++;
        if (sda_slave != s0) begin
            mismatched++;
            $display("FAIL nack_sda_driven: got %0d low clks, required 0", sda_slave - s0);
        end
        compared++;
        if (rx_pulses != rx0 || tx_pulses != tx0) begin
            mismatched++;
            $display("FAIL nack_strobes: got wr=%0d rd=%0d, required 0 0",
                     rx_pulses - rx0, tx_pulses - tx0);
        end
        i2c_slave_enable = 1'b0;
        i2c_start();
        write_byte(8'hA0, ack);
        i2c_stop();
        i2c_slave_enable = 1'b1;
        compared++;
        if (ack !== 1'b0) begin
            mismatched++;
            $display("FAIL disabled_ack: got ack=%b, required 0", ack);
        end
    endtask

    task automatic test_read();
        logic ack;
        logic [7:0] b;
        int tx0 = tx_pulses;
        tx_q.push_back(8'h96);
        tx_q.push_back(8'h0F);
        exp_q.push_back(8'h96);
        exp_q.push_back(8'h0F);
        tick(2);
        i2c_start();
        write_byte(8'hA1, ack);
        compared++;
        if (ack !== 1'b1) begin
            mismatched++;
            $display("FAIL read_addr_ack: got ack=%b, required 1", ack);
        end
        read_byte(b, 1'b1);
        got_q.push_back(b);
        read_byte(b, 1'b0);
        got_q.push_back(b);
        i2c_stop();
        while (exp_q.size() > 0) begin
            logic [7:0] e = exp_q.pop_front();
            logic [7:0] g = got_q.size() > 0 ? got_q.pop_front() : 8'hxx;
            compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL read_byte: got %h, required %h", g, e);
            end
        end
        compared++;
        if (tx_pulses - tx0 != 2) begin
            mismatched++;
            $display("FAIL read_pops: got %0d, required 2", tx_pulses - tx0);
        end
    endtask

    task automatic test_read_empty();
        logic ack;
        logic [7:0] b;
        logic [7:0] e;
        int tx0 = tx_pulses;
        int s0  = scl_slave;
        int pops_req;
        i2c_start();
        write_byte(8'hA1, ack);
`ifdef I2C_SLAVE_STRETCH_EN
        fork
            read_byte(b, 1'b0);
            begin
                int n = 0;
                while (scl_slave == s0 && n < 3000) begin
                    tick(1);
                    n++;
                end
                tick(40);
                tx_q.push_back(8'h42);
            end
        join
        e = 8'h42;
        pops_req = 1;
        compared++;
        if (scl_slave == s0) begin
            mismatched++;
            $display("FAIL empty_stretch: got 0 stretched clks, required >0");
        end
`else
        read_byte(b, 1'b0);
        e = 8'hFF;
        pops_req = 0;
        compared++;
        if (scl_slave != s0) begin
            mismatched++;
            $display("FAIL empty_scl_driven: got %0d clks, required 0", scl_slave - s0);
        end
`endif
        i2c_stop();
        compared++;
        if (b !== e) begin
            mismatched++;
            $display("FAIL empty_byte: got %h, required %h", b, e);
        end
        compared++;
        if (tx_pulses - tx0 != pops_req || bad_pops != 0) begin
            mismatched++;
            $display("FAIL empty_pops: got %0d (bad %0d), required %0d (bad 0)",
                     tx_pulses - tx0, bad_pops, pops_req);
        end
    endtask

    task automatic test_rx_full();
        logic ack_a;
        logic ack_d;
        int rx0 = rx_pulses;
        fifo_rx_full = 1'b1;
        i2c_start();
        write_byte(8'hA0, ack_a);
        write_byte(8'h11, ack_d);
        i2c_stop();
        fifo_rx_full = 1'b0;
        compared++;
        if (ack_a !== 1'b1 || ack_d !== 1'b0) begin
            mismatched++;
            $display("FAIL full_acks: got addr=%b data=%b, required 1 0", ack_a, ack_d);
        end
        compared++;
        if (rx_pulses != rx0) begin
            mismatched++;
            $display("FAIL full_pulses: got %0d, required 0", rx_pulses - rx0);
        end
        compared++;
        if (i2c_data_out !== 8'h11) begin
            mismatched++;
            $display("FAIL full_data_out: got %h, required 11", i2c_data_out);
        end
    endtask

    task automatic test_reset_mid();
        logic ack;
        logic ack2;
        int rx0;
        i2c_start();
        write_byte(8'hA0, ack);
        for (int i = 0; i < 4; i++) write_bit(i < 2);
        m_sda_low = 1'b0;
        i2c_reset = 1'b1;
        tick(1);
        compared++;
        if (sda_bus !== 1'b1 || i2c_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_release: sda=%b busy=%b, required 1 0", sda_bus, i2c_busy);
        end
        tick(4);
        i2c_reset = 1'b0;
        rx0 = rx_pulses;
        tick(4);
        scl_high();
        tick(2 * Q);
        exp_q.push_back(8'h77);
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h77, ack2);
        i2c_stop();
        compared++;
        if (ack !== 1'b1 || ack2 !== 1'b1) begin
            mismatched++;
            $display("FAIL midreset_acks: got %b %b, required 1 1", ack, ack2);
        end
        compared++;
        if (rx_pulses - rx0 != 1) begin
            mismatched++;
            $display("FAIL midreset_pulses: got %0d, required 1", rx_pulses - rx0);
        end
        rx_got = rx_got[rx_got.size() > 0 ? rx_got.size() - 1 : 0 : rx_got.size() - 1];
        while (exp_q.size() > 0) begin
            logic [7:0] e = exp_q.pop_front();
            logic [7:0] g = rx_got.size() > 0 ? rx_got.pop_front() : 8'hxx;
            compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL midreset_rx_byte: got %h, required %h", g, e);
            end
        end
    endtask

    initial begin
        m_scl_low        = 1'b0;
        m_sda_low        = 1'b0;
        i2c_slave_enable = 1'b1;
        fifo_rx_full     = 1'b0;
        i2c_reset        = 1'b1;
        test_reset();
        test_write();
        test_addr_nack();
        test_read();
        test_read_empty();
        test_rx_full();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at 3 ms, required to finish");
        $fatal(1);
    end

endmodule
